// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: message-atomic round-robin share of one UART TX core.
// Ports: clk; rst_n (async, active-high); req_valid/req_data/req_last/req_ready
// per requester; grant (one-hot owner); tx_start/tx_data/tx_busy to the UART
// core; timeout_evt. Optional stall timeout: define UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int N_REQ          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   grant,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  input  logic               tx_busy,
  output logic               timeout_evt
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOCKED,
    S_SEND,
    S_WAIT_BUSY,
    S_WAIT_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     last_owner_q, last_owner_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [N_REQ-1:0]  ready_q, ready_d;
  logic [7:0]        data_q, data_d;
  logic              last_q, last_d;
  logic              start_q, start_d;
  logic              evt_q, evt_d;

  logic              lo_found, hi_found, win_found;
  logic [IW-1:0]     lo_idx, hi_idx, win_idx;
  logic [7:0]        sel_data;
  logic              sel_last;
  logic              accept;
  logic              tmo_hit;

  // Round robin: lowest valid index above last_owner, else lowest valid.
  // Scanning downward lets the last hit in each class be the lowest one.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = IW'(i);
        if (i > int'(last_owner_q)) begin
          hi_found = 1'b1;
          hi_idx   = IW'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q[i]) begin
        sel_data = req_data[8*i +: 8];
        sel_last = req_last[i];
      end
    end
  end

  // ready_q only ever carries the owner's bit
  assign accept = (state_q == S_LOCKED) && |(req_valid & ready_q);

`ifdef UART_ARB_TIMEOUT_EN
  logic        sel_valid;
  logic [16:0] tmo_cnt_q;

  assign sel_valid = |(req_valid & grant_q);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      tmo_cnt_q <= '0;
    end else if (state_q != S_LOCKED || accept) begin
      tmo_cnt_q <= '0;
    end else if (!sel_valid) begin
      tmo_cnt_q <= tmo_cnt_q + 17'd1;
    end
  end

  // fires on the TIMEOUT_CYCLES-th stalled cycle
  assign tmo_hit = (state_q == S_LOCKED) && !sel_valid &&
                   (tmo_cnt_q == 17'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:      if (win_found) state_d = S_LOCKED;
      S_LOCKED: begin
        if (accept)       state_d = S_SEND;
        else if (tmo_hit) state_d = S_IDLE;
      end
      S_SEND:      state_d = S_WAIT_BUSY;
      S_WAIT_BUSY: if (tx_busy) state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (!tx_busy) state_d = last_q ? S_IDLE : S_LOCKED;
      end
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_d      = grant_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    data_d       = data_q;
    last_d       = last_q;
    start_d      = 1'b0;
    evt_d        = 1'b0;
    ready_d      = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          grant_d = N_REQ'(1) << win_idx;
        end
      end
      S_LOCKED: begin
        if (accept) begin
          data_d  = sel_data;
          last_d  = sel_last;
          start_d = 1'b1;
        end else if (tmo_hit) begin
          grant_d      = '0;
          last_owner_d = owner_q;
          evt_d        = 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy && last_q) begin
          grant_d      = '0;
          last_owner_d = owner_q;
        end
      end
      default: ;
    endcase
    // Ready is registered; gating on tx_busy here keeps a frame still
    // running after reset from being overlapped by a new start.
    if (state_d == S_LOCKED && !tx_busy) begin
      ready_d = N_REQ'(1) << owner_d;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      grant_q      <= '0;
      owner_q      <= '0;
      last_owner_q <= IW'(N_REQ - 1);
      ready_q      <= '0;
      data_q       <= 8'h00;
      last_q       <= 1'b0;
      start_q      <= 1'b0;
      evt_q        <= 1'b0;
    end else begin
      grant_q      <= grant_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      ready_q      <= ready_d;
      data_q       <= data_d;
      last_q       <= last_d;
      start_q      <= start_d;
      evt_q        <= evt_d;
    end
  end

  assign grant       = grant_q;
  assign req_ready   = ready_q;
  assign tx_start    = start_q;
  assign tx_data     = data_q;
  assign timeout_evt = evt_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed bench for uart_tx_arbiter with a
// tx_busy responder and per-requester byte queues.
module tb_uart_tx_arbiter;

  localparam int FRAME = 12;
`ifdef UART_ARB_TIMEOUT_EN
  localparam int STALL = 99;
`else
  localparam int STALL = 100;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic [3:0]  grant;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;
  logic        timeout_evt;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(4), .TIMEOUT_CYCLES(100)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready),
    .grant(grant), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .timeout_evt(timeout_evt)
  );

  typedef struct packed {
    logic [3:0]  vld;
    logic [31:0] dat;
    logic [2:0]  n;
    logic [7:0]  ord;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [8:0]  mem [4][16];
  logic [3:0]  head [4];
  logic [3:0]  tail [4];
  logic [3:0]  stall;
  logic [3:0]  acc;
  logic [9:0]  log_q [$];
  int          bcnt;
  int          starts;
  int          evt_cnt;
  logic [7:0]  cur;
  bit          stab_ok;
  vec_t        vt [6];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [1:0] oh2i(input logic [3:0] g);
    oh2i = '0;
    for (int i = 3; i >= 0; i--) if (g[i]) oh2i = 2'(i);
  endfunction

  task automatic push(input int r, input logic [7:0] d, input logic l);
    mem[r][tail[r]] = {l, d};
    tail[r] = tail[r] + 4'd1;
  endtask

  function automatic bit queues_empty();
    queues_empty = 1'b1;
    for (int i = 0; i < 4; i++) if (head[i] != tail[i]) queues_empty = 1'b0;
  endfunction

  task automatic wait_idle(input int n, input string nm);
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk); #1;
      if (log_q.size() >= n && grant == 4'd0 && !tx_busy &&
          queues_empty()) break;
    end
    chk(nm, log_q.size(), n);
  endtask

  task automatic wait_log(input int n);
    for (int c = 0; c < 500; c++) begin
      @(negedge clk); #1;
      if (log_q.size() >= n) break;
    end
  endtask

  task automatic exp_log(input int k, input logic [1:0] o,
                         input logic [7:0] d, input string nm);
    logic [9:0] a;
    a = (k < log_q.size()) ? log_q[k] : 10'h3ff;
    chk(nm, a, {o, d});
  endtask

  // UART core model + requester drivers, all updated on the falling edge
  initial begin
    tx_busy = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    acc = '0; bcnt = 0; starts = 0; evt_cnt = 0; stab_ok = 1'b0;
    cur = '0;
    for (int i = 0; i < 4; i++) begin head[i] = '0; tail[i] = '0; end
    forever begin
      @(negedge clk);
      if (timeout_evt) evt_cnt++;
      if (tx_start) begin
        chk("start_when_idle", tx_busy, 0);
        chk("grant_onehot", $countones(grant), 1);
        log_q.push_back({oh2i(grant), tx_data});
        cur = tx_data; stab_ok = 1'b1; bcnt = FRAME; starts++;
      end else if (tx_busy && stab_ok) begin
        chk("tx_data_stable", tx_data, cur);
      end
      if (bcnt > 0) begin tx_busy = 1'b1; bcnt--; end
      else tx_busy = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (acc[i] && head[i] != tail[i]) head[i] = head[i] + 4'd1;
        if (head[i] != tail[i] && !stall[i]) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = mem[i][head[i]][7:0];
          req_last[i] = mem[i][head[i]][8];
        end else begin
          req_valid[i] = 1'b0;
        end
        acc[i] = req_valid[i] & req_ready[i];
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int s0;
    vt[0] = '{vld:4'b0001, dat:32'h0000_0041, n:3'd1, ord:8'h00};
    vt[1] = '{vld:4'b0110, dat:32'h0032_3100, n:3'd2, ord:8'h09};
    vt[2] = '{vld:4'b1011, dat:32'h5300_5150, n:3'd3, ord:8'h13};
    vt[3] = '{vld:4'b1111, dat:32'h6362_6160, n:3'd4, ord:8'h4e};
    vt[4] = '{vld:4'b0010, dat:32'h0000_7100, n:3'd1, ord:8'h01};
    vt[5] = '{vld:4'b0101, dat:32'h0082_0080, n:3'd2, ord:8'h02};
    stall = '0;
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_start", tx_start, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_evt", timeout_evt, 0);
    @(posedge clk); #1 rst_n = 1'b0;

    // arbitration and byte-path latency
    @(posedge clk); #1;
    log_q.delete();
    push(3, 8'h5a, 1'b1);
    @(negedge clk); @(negedge clk); #1;
    chk("lat_grant", grant, 4'b1000);
    chk("lat_ready", req_ready, 4'b1000);
    @(negedge clk); #1;
    chk("lat_start", tx_start, 1);
    chk("lat_data", tx_data, 8'h5a);
    chk("lat_ready_drop", req_ready, 0);
    @(negedge clk); #1;
    chk("lat_start_pulse", tx_start, 0);
    wait_idle(1, "lat_done");

    // atomicity: "HI\n" from req0 before req3's byte
    @(posedge clk); #1;
    log_q.delete();
    push(0, 8'h48, 1'b0); push(0, 8'h49, 1'b0); push(0, 8'h0a, 1'b1);
    push(3, 8'h33, 1'b1);
    wait_idle(4, "atom_cnt");
    exp_log(0, 2'd0, 8'h48, "atom0");
    exp_log(1, 2'd0, 8'h49, "atom1");
    exp_log(2, 2'd0, 8'h0a, "atom2");
    exp_log(3, 2'd3, 8'h33, "atom3");

    // single-byte message sets, round-robin order
    for (int v = 0; v < 6; v++) begin
      @(posedge clk); #1;
      log_q.delete();
      for (int i = 0; i < 4; i++)
        if (vt[v].vld[i]) push(i, vt[v].dat[8*i +: 8], 1'b1);
      wait_idle(int'(vt[v].n), $sformatf("vec%0d_cnt", v));
      for (int k = 0; k < int'(vt[v].n); k++) begin
        logic [1:0] o;
        o = vt[v].ord[2*k +: 2];
        exp_log(k, o, vt[v].dat[8*o +: 8], $sformatf("vec%0d_b%0d", v, k));
      end
    end

    // continuous contention alternates 1,2,1,2
    @(posedge clk); #1;
    log_q.delete();
    push(1, 8'ha1, 1'b1); push(1, 8'ha2, 1'b1);
    push(2, 8'hb1, 1'b1); push(2, 8'hb2, 1'b1);
    wait_idle(4, "alt_cnt");
    exp_log(0, 2'd1, 8'ha1, "alt0");
    exp_log(1, 2'd2, 8'hb1, "alt1");
    exp_log(2, 2'd1, 8'ha2, "alt2");
    exp_log(3, 2'd2, 8'hb2, "alt3");

    // stall mid-message holds the grant and sends nothing
    @(posedge clk); #1;
    log_q.delete();
    push(1, 8'h61, 1'b0); push(1, 8'h62, 1'b0); push(1, 8'h63, 1'b1);
    wait_log(1);
    stall[1] = 1'b1;
    s0 = starts;
    repeat (STALL) @(negedge clk);
    #1;
    chk("stall_starts", starts - s0, 0);
    chk("stall_grant", grant, 4'b0010);
    stall[1] = 1'b0;
    wait_idle(3, "stall_cnt");
    exp_log(0, 2'd1, 8'h61, "stall0");
    exp_log(1, 2'd1, 8'h62, "stall1");
    exp_log(2, 2'd1, 8'h63, "stall2");
    chk("stall_no_evt", evt_cnt, 0);

    // reset during the first frame of a 3-byte message
    @(posedge clk); #1;
    log_q.delete();
    push(0, 8'h71, 1'b0); push(0, 8'h72, 1'b0); push(0, 8'h73, 1'b1);
    wait_log(1);
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
    stab_ok = 1'b0;
    for (int i = 0; i < 4; i++) head[i] = tail[i];
    @(negedge clk); #1;
    chk("mrst_grant", grant, 0);
    chk("mrst_ready", req_ready, 0);
    chk("mrst_start", tx_start, 0);
    chk("mrst_data", tx_data, 0);
    chk("mrst_evt", timeout_evt, 0);
    @(posedge clk); #1 rst_n = 1'b0;
    push(0, 8'h74, 1'b1);
    wait_idle(2, "mrst_cnt");
    exp_log(0, 2'd0, 8'h71, "mrst0");
    exp_log(1, 2'd0, 8'h74, "mrst1");

`ifdef UART_ARB_TIMEOUT_EN
    // owner stalls past the limit; pending req1 takes over
    @(posedge clk); #1;
    log_q.delete();
    push(0, 8'h81, 1'b0); push(0, 8'h82, 1'b1);
    wait_log(1);
    stall[0] = 1'b1;
    push(1, 8'h91, 1'b1);
    for (int c = 0; c < 400; c++) begin
      @(negedge clk); #1;
      if (timeout_evt) break;
    end
    chk("tmo_evt", timeout_evt, 1);
    chk("tmo_grant_clr", grant, 0);
    @(negedge clk); #1;
    chk("tmo_regrant", grant, 4'b0010);
    chk("tmo_pulse", timeout_evt, 0);
    stall[0] = 1'b0;
    wait_idle(3, "tmo_cnt");
    exp_log(1, 2'd1, 8'h91, "tmo1");
    exp_log(2, 2'd0, 8'h82, "tmo2");
    chk("tmo_evt_once", evt_cnt, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares the SoC's single UART transmitter among several byte-stream requesters (CPU console, fault logger, debug monitor). Grants are message-atomic: once a requester wins, it keeps the transmitter until it sends a byte flagged `last`. The block issues one `tx_start` pulse per byte to the UART TX core and tracks the core's `tx_busy` to sequence the next byte. It sits between the peripheral bus requesters and the UART TX core inside `soc_top`, in the 50 MHz clock domain.

## Interface
- `N_REQ`, 4 — number of requesters; 2..8.
- `TIMEOUT_CYCLES`, 50000 — idle cycles a locked requester may stall before its grant is revoked. Used only with `UART_ARB_TIMEOUT_EN`.
- `clk` in 1 — 50 MHz system clock.
- `rst_n` in 1 — reset, asynchronous, active-high. Logic is held in reset while `rst_n`=1.
- `req_valid` in N_REQ — per-requester byte valid.
- `req_data` in 8·N_REQ — byte for requester i, carried on bits [8i+7:8i].
- `req_last` in N_REQ — marks the final byte of a message; sampled on accept.
- `req_ready` out N_REQ — byte accepted when `req_valid[i]` & `req_ready[i]`.
- `grant` out N_REQ — one-hot owner of the transmitter; 0 when idle.
- `tx_start` out 1 — single-cycle start pulse to the UART TX core.
- `tx_data` out 8 — byte to send; registered and stable from `tx_start` until `tx_busy` falls.
- `tx_busy` in 1 — UART core is busy, covering start bit through stop bit.
- `timeout_evt` out 1 — single-cycle pulse when a grant is revoked by timeout.

## Operation
- **States:** IDLE, LOCKED, SEND, WAIT_BUSY, WAIT_DONE.
- **IDLE:**
  - If any `req_valid` is high, select a winner round-robin: the first valid index strictly after `last_owner`, wrapping modulo N_REQ.
  - Register `grant`, then go to LOCKED.
  - `last_owner` resets to N_REQ-1, so requester 0 wins first.
- **LOCKED:**
  - `req_ready[g]` = 1 only for the granted index g, and only while `tx_busy` = 0. All other `req_ready` bits are 0.
  - On accept: latch `req_data[g]` into `tx_data`, latch `req_last[g]` into `last_q`, then go to SEND.
- **SEND:** `tx_start` = 1 for exactly this cycle, then go to WAIT_BUSY.
- **WAIT_BUSY:** wait for `tx_busy` = 1, then go to WAIT_DONE.
- **WAIT_DONE:** wait for `tx_busy` = 0, then:
  - if `last_q` = 1: clear `grant`, set `last_owner` = g, go to IDLE;
  - otherwise return to LOCKED.
- **Atomicity:** requests from other requesters are ignored while `grant` ≠ 0, whatever their index.
- **`req_valid` dropped in LOCKED:** no byte is sent and the grant is held (unless a timeout fires).
- **Simultaneous requests in IDLE:** resolved by the round-robin pointer only. There is no fixed priority.
- **Reset mid-message:** all state clears. The UART core may still finish its current frame; the arbiter returns to IDLE and waits for `tx_busy` = 0 before it issues any new `tx_start`.
- **Reset values:** `grant` = 0, `req_ready` = 0, `tx_start` = 0, `tx_data` = 8'h00, `timeout_evt` = 0, state IDLE.

## Timing
- Arbitration: `req_valid` sampled high in IDLE at cycle k gives `grant` at k+1. The earliest `req_ready` is also at k+1.
- Byte path: accept at cycle a gives `tx_start` at a+1. The next `req_ready` comes no earlier than one cycle after `tx_busy` falls.
- Inter-message gap: 1 cycle (WAIT_DONE → IDLE) plus 1 arbitration cycle.
- Per-byte overhead beyond the UART frame time: at most 3 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- **`UART_ARB_TIMEOUT_EN` defined:**
  - A 17-bit counter runs in LOCKED while `req_valid[g]` = 0, and clears on any accept.
  - When it reaches `TIMEOUT_CYCLES`, clear `grant`, pulse `timeout_evt` for 1 cycle, set `last_owner` = g, and go to IDLE.
- **Not defined:** the counter is absent, `timeout_evt` is tied to 0, and a stalled owner holds the grant indefinitely.

## Test plan
- **Single byte:** requester 0 sends 0x41 with `last` = 1 → one `tx_start` with `tx_data` = 0x41; `grant` returns to 0 after `tx_busy` falls; the UART line decodes 'A'.
- **Contention:** requesters 1 and 2 both present single-byte messages 0x31 and 0x32 from reset → 0x31 is sent first, then 0x32.
  - Repeat with both requesters continuously valid → grants alternate 1, 2, 1, 2.
- **Atomicity:** requester 0 sends "HI\n" (0x48, 0x49, 0x0A; `last` on 0x0A) while requester 3 is valid throughout → the three bytes go out contiguously before requester 3 is granted.
- **Stall:** `req_valid` is dropped for 100 cycles mid-message → no `tx_start` during the stall; the grant is held; transmission resumes afterwards.
- **Reset mid-message:** assert `rst_n` = 1 during the WAIT_DONE of byte 1 of 3 → all outputs return to their reset values; after release, no `tx_start` is issued until `tx_busy` = 0.
- **Timeout (`UART_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 100):**
  - Owner stalls 100 cycles after its first byte → `timeout_evt` pulses once and the pending requester 1 is granted on the next cycle.
  - Owner stalls only 99 cycles → no timeout.
